move_btn_ctl: RTL and testbench

MOVE_BTN_CTL -- requirements
Module: move_btn_ctl

---
 rtl/move_btn_ctl.sv | 181 ++++++++++++++++++
 tb/tb_move_btn_ctl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/move_btn_ctl.sv
// Left/right move-button controller: synchronize, debounce and edge-detect two buttons into single-cycle move pulses.
// Optional auto-repeat on held buttons is enabled by defining MOVE_BTN_AUTOREPEAT_EN.
module move_btn_ctl #(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int REPEAT_DELAY    = 12000000,
    parameter int REPEAT_PERIOD   = 4000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    input  logic endgame,
    output logic left,
    output logic right
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);

    // Channel index 0 is left, 1 is right throughout.
    logic [1:0]    btn_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    deb_r;
    logic [1:0]    deb_d_r;
    logic [DW-1:0] cnt_r [2];
    logic [1:0]    press_s;
    logic [1:0]    pulse_s;
    logic          left_s;
    logic          right_s;

    assign btn_s   = {btn_right, btn_left};
    assign press_s = deb_r & ~deb_d_r;

    // Two-flop synchronizers for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counters: the level flips only after DEBOUNCE_CYCLES+1 consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == deb_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == DEB_MAX) begin
                    cnt_r[i] <= '0;
                    deb_r[i] <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + DW'(1);
                end
            end
        end
    end

`ifdef MOVE_BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    rep_state_t    state_r [2];
    rep_state_t    state_s [2];
    logic [RW-1:0] rcnt_r  [2];
    logic [RW-1:0] rcnt_s  [2];
    logic [1:0]    rep_s;

    // Repeat FSM state and interval counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= ST_IDLE;
                rcnt_r[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= state_s[i];
                rcnt_r[i]  <= rcnt_s[i];
            end
        end
    end

    // Repeat FSM next state; a debounced release aborts any pending repeat in the same cycle.
    always_comb begin
        rep_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_s[i] = state_r[i];
            rcnt_s[i]  = rcnt_r[i] + RW'(1);
            case (state_r[i])
                ST_IDLE: begin
                    rcnt_s[i] = '0;
                    if (press_s[i]) begin
                        state_s[i] = ST_DELAY;
                    end else begin
                        state_s[i] = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (!deb_r[i]) begin
                        state_s[i] = ST_IDLE;
                        rcnt_s[i]  = '0;
                    end else if (rcnt_r[i] == DELAY_LAST) begin
                        state_s[i] = ST_REPEAT;
                        rcnt_s[i]  = '0;
                        rep_s[i]   = 1'b1;
                    end else begin
                        state_s[i] = ST_DELAY;
                    end
                end
                ST_REPEAT: begin
                    if (!deb_r[i]) begin
                        state_s[i] = ST_IDLE;
                        rcnt_s[i]  = '0;
                    end else if (rcnt_r[i] == PERIOD_LAST) begin
                        rcnt_s[i]  = '0;
                        rep_s[i]   = 1'b1;
                    end else begin
                        state_s[i] = ST_REPEAT;
                    end
                end
                default: begin
                    state_s[i] = ST_IDLE;
                    rcnt_s[i]  = '0;
                end
            endcase
        end
    end

    assign pulse_s = press_s | rep_s;
`else
    assign pulse_s = press_s;
`endif

    // Simultaneous left/right pulses cancel each other; endgame discards pulses outright.
    always_comb begin
        left_s  = 1'b0;
        right_s = 1'b0;
        if (endgame) begin
            left_s  = 1'b0;
            right_s = 1'b0;
        end else if (pulse_s == 2'b01) begin
            left_s  = 1'b1;
        end else if (pulse_s == 2'b10) begin
            right_s = 1'b1;
        end else begin
            left_s  = 1'b0;
            right_s = 1'b0;
        end
    end

    // Registered move pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left  <= 1'b0;
            right <= 1'b0;
        end else begin
            left  <= left_s;
            right <= right_s;
        end
    end

endmodule

// File: tb/tb_move_btn_ctl.sv
// Directed bench for move_btn_ctl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Expected pulses are hand-derived edge numbers; auto-repeat expectations follow MOVE_BTN_AUTOREPEAT_EN.
module tb_move_btn_ctl;

`ifdef MOVE_BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic btn_left;
    logic btn_right;
    logic endgame;
    logic left;
    logic right;

    int total;
    int bad;

    move_btn_ctl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .endgame  (endgame),
        .left     (left),
        .right    (right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask

    // Pulse expected after edge e for a button first sampled high at edge p and released at edge r.
    function automatic bit exp_pulse(input int e, input int p, input int r);
        int first;
        first = p + 7;
        if (e == first) return 1'b1;
        if (AR && e >= first + 10 && ((e - first - 10) % 5) == 0 && e <= r + 6) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cyc(input logic bl, input logic br, input logic eg,
                       input logic el, input logic er, input string tag, input int e);
        @(negedge clk);
        btn_left  = bl;
        btn_right = br;
        endgame   = eg;
        @(posedge clk);
        #1;
        check($sformatf("%s.left@%0d", tag, e), left, el);
        check($sformatf("%s.right@%0d", tag, e), right, er);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        endgame   = 1'b0;
        #1;
        check("rst.left", left, 1'b0);
        check("rst.right", right, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        endgame   = 1'b0;
        do_reset();

        // Press at 0, release at 40, press again at 50.
        for (int e = 0; e <= 62; e++) begin
            cyc((e < 40) || (e >= 50), 1'b0, 1'b0,
                exp_pulse(e, 0, 40) || exp_pulse(e, 50, 1000), 1'b0, "hold", e);
        end

        // Right bounces every 2 cycles, then settles high from edge 12.
        do_reset();
        for (int e = 0; e <= 25; e++) begin
            cyc(1'b0, (e >= 12) ? 1'b1 : (((e / 2) % 2) == 0), 1'b0,
                1'b0, exp_pulse(e, 12, 1000), "bounce", e);
        end

        // Both pressed on the same edge cancel.
        do_reset();
        for (int e = 0; e <= 25; e++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "both", e);
        end

        // Endgame suppresses the press pulse without queueing it.
        do_reset();
        for (int e = 0; e <= 25; e++) begin
            cyc(1'b1, 1'b0, (e < 15), exp_pulse(e, 0, 1000) && !(e < 15), 1'b0, "endgame", e);
        end

        // Left held, right pressed later still gets its pulse.
        do_reset();
        for (int e = 0; e <= 30; e++) begin
            cyc(1'b1, (e >= 12), 1'b0, exp_pulse(e, 0, 1000), exp_pulse(e, 12, 1000), "held", e);
        end

        // Reset mid-debounce from edge 3 to edge 5 with the button still held.
        do_reset();
        for (int e = 0; e <= 20; e++) begin
            @(negedge clk);
            if (e == 3) rst_n = 1'b0;
            if (e == 5) rst_n = 1'b1;
            btn_left = 1'b1;
            if (e == 3) begin
                #1;
                check("midrst.async.left", left, 1'b0);
                check("midrst.async.right", right, 1'b0);
            end
            @(posedge clk);
            #1;
            check($sformatf("midrst.left@%0d", e), left, (e >= 5) && exp_pulse(e, 5, 1000));
            check($sformatf("midrst.right@%0d", e), right, 1'b0);
        end

        // Reset asserted while a pulse is on the output clears it at once.
        do_reset();
        for (int e = 0; e <= 7; e++) begin
            cyc(1'b1, 1'b0, 1'b0, (e == 7), 1'b0, "asyncrst", e);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check("asyncrst.left", left, 1'b0);
        check("asyncrst.right", right, 1'b0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
